// File: rtl/m68k_bus_pkg.sv
// Shared types and memory map for the 68000 bus cycle controller.
// Region codes double as chip-select bit indices for the first five regions.
package m68k_bus_pkg;

    typedef enum logic [2:0] {
        REG_ROM      = 3'd0,
        REG_RAM      = 3'd1,
        REG_TILE     = 3'd2,
        REG_PAL      = 3'd3,
        REG_IO       = 3'd4,
        REG_IACK     = 3'd5,
        REG_UNMAPPED = 3'd6
    } region_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WAIT,
        ST_ACK,
        ST_END
    } state_t;

    localparam logic [23:0] ROM_BASE  = 24'h000000;
    localparam logic [23:0] ROM_LIMIT = 24'h05FFFF;
    localparam logic [23:0] RAM_BASE  = 24'h060000;
    localparam logic [23:0] RAM_LIMIT = 24'h063FFF;
    localparam logic [23:0] IO_BASE   = 24'h0A0000;
    localparam logic [23:0] IO_LIMIT  = 24'h0A001F;
    localparam logic [23:0] TILE_BASE = 24'h100000;
    localparam logic [23:0] TILE_LIMIT= 24'h107FFF;
    localparam logic [23:0] PAL_BASE  = 24'h140000;
    localparam logic [23:0] PAL_LIMIT = 24'h140FFF;
    localparam logic [2:0]  FC_IACK   = 3'b111;

    function automatic logic in_range(input logic [23:0] a, input logic [23:0] lo,
                                      input logic [23:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

    // Active-high select vector: bit0 ROM, bit1 RAM, bit2 TILE, bit3 PAL, bit4 IO.
    function automatic logic [4:0] cs_onehot(input region_t r);
        case (r)
            REG_ROM:  return 5'b00001;
            REG_RAM:  return 5'b00010;
            REG_TILE: return 5'b00100;
            REG_PAL:  return 5'b01000;
            REG_IO:   return 5'b10000;
            default:  return 5'b00000;
        endcase
    endfunction

endpackage

// File: rtl/m68k_addr_decode.sv
// Combinational decode of word address + function code into a bus region.
// Interrupt-acknowledge (FC=111) wins over any address match.
module m68k_addr_decode
    import m68k_bus_pkg::*;
(
    input  logic [23:1] i_addr,
    input  logic [2:0]  i_fc,
    output region_t     o_region
);

    logic [23:0] w_byte;
    assign w_byte = {i_addr, 1'b0};

    always_comb begin
        o_region = REG_UNMAPPED;
        if (i_fc == FC_IACK)                          o_region = REG_IACK;
        else if (in_range(w_byte, ROM_BASE,  ROM_LIMIT))  o_region = REG_ROM;
        else if (in_range(w_byte, RAM_BASE,  RAM_LIMIT))  o_region = REG_RAM;
        else if (in_range(w_byte, IO_BASE,   IO_LIMIT))   o_region = REG_IO;
        else if (in_range(w_byte, TILE_BASE, TILE_LIMIT)) o_region = REG_TILE;
        else if (in_range(w_byte, PAL_BASE,  PAL_LIMIT))  o_region = REG_PAL;
    end

endmodule

// File: rtl/m68k_bus_ctrl.sv
// 68000 bus cycle controller: chip selects, wait states, nDTACK, read mux, autovector IACK.
// Optional DTACK_TIMEOUT_EN: bounded TILE wait with forced ACK and sticky TMO output.
module m68k_bus_ctrl
    import m68k_bus_pkg::*;
#(
    parameter int WS_ROM  = 2,
    parameter int WS_RAM  = 0,
    parameter int WS_PAL  = 1,
    parameter int WS_IO   = 1,
    parameter int TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        nRESET,
    input  logic [23:1] M68K_ADDR,
    input  logic        nAS,
    input  logic        nUDS,
    input  logic        nLDS,
    input  logic        M68K_RW,
    input  logic [2:0]  FC,
    output logic        nDTACK,
    output logic [15:0] FX68K_DATAIN,
    input  logic [15:0] ROM_D,
    input  logic [15:0] RAM_D,
    input  logic [15:0] PAL_D,
    input  logic [15:0] IO_D,
    input  logic [15:0] TILE_D,
    input  logic        TILE_RDY,
    output logic        nROMCS,
    output logic        nRAMCS,
    output logic        nPALCS,
    output logic        nIOCS,
    output logic        nTILECS,
    output logic        nWRU,
    output logic        nWRL,
    output logic        IACK,
    output logic [2:0]  IACK_LVL
`ifdef DTACK_TIMEOUT_EN
    ,
    output logic        TMO
`endif
);

    state_t      r_state;
    region_t     r_region;
    logic [5:0]  r_wcnt;
    logic        r_ndtack;
    logic [4:0]  r_ncs;
    logic        r_nwru;
    logic        r_nwrl;
    logic        r_iack;
    logic [2:0]  r_iack_lvl;
    logic [15:0] r_data;
`ifdef DTACK_TIMEOUT_EN
    logic        r_tmo;
`endif

    region_t     w_region;
    logic [4:0]  w_cs_new;
    logic [5:0]  w_ws;
    logic [15:0] w_rdata;
    logic        w_active;
    logic        w_nwru;
    logic        w_nwrl;

    m68k_addr_decode u_dec (
        .i_addr   (M68K_ADDR),
        .i_fc     (FC),
        .o_region (w_region)
    );

    function automatic logic [5:0] ws_of(input region_t r);
        case (r)
            REG_ROM: return 6'(WS_ROM);
            REG_RAM: return 6'(WS_RAM);
            REG_PAL: return 6'(WS_PAL);
            REG_IO:  return 6'(WS_IO);
            default: return 6'd0;
        endcase
    endfunction

    assign w_cs_new = cs_onehot(w_region);
    assign w_ws     = ws_of(r_region);
    assign w_active = (r_state == ST_DECODE) || (r_state == ST_WAIT) || (r_state == ST_ACK);
    // Byte strobes track the core's UDS/LDS while the cycle is live (they may lag AS on writes).
    assign w_nwru   = nUDS | M68K_RW | (&r_ncs);
    assign w_nwrl   = nLDS | M68K_RW | (&r_ncs);

    always_comb begin
        w_rdata = 16'hFFFF;
        case (r_region)
            REG_ROM:  w_rdata = ROM_D;
            REG_RAM:  w_rdata = RAM_D;
            REG_TILE: w_rdata = TILE_D;
            REG_PAL:  w_rdata = PAL_D;
            REG_IO:   w_rdata = IO_D;
            REG_IACK: w_rdata = {8'h00, 5'd3, r_iack_lvl};
            default:  w_rdata = 16'hFFFF;
        endcase
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            r_state    <= ST_IDLE;
            r_region   <= REG_UNMAPPED;
            r_wcnt     <= 6'd0;
            r_ndtack   <= 1'b1;
            r_ncs      <= 5'h1F;
            r_nwru     <= 1'b1;
            r_nwrl     <= 1'b1;
            r_iack     <= 1'b0;
            r_iack_lvl <= 3'd0;
            r_data     <= 16'h0000;
`ifdef DTACK_TIMEOUT_EN
            r_tmo      <= 1'b0;
`endif
        end else begin
            r_iack <= 1'b0;
            // AS released: a completed cycle closes, an unfinished one aborts without DTACK.
            if (w_active && nAS) begin
                r_state  <= ST_END;
                r_ndtack <= 1'b1;
                r_ncs    <= 5'h1F;
                r_nwru   <= 1'b1;
                r_nwrl   <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: if (!nAS) begin
                        r_state  <= ST_DECODE;
                        r_region <= w_region;
                        r_ncs    <= ~w_cs_new;
                        r_nwru   <= nUDS | M68K_RW | ~(|w_cs_new);
                        r_nwrl   <= nLDS | M68K_RW | ~(|w_cs_new);
                        if (w_region == REG_IACK) begin
                            r_iack     <= 1'b1;
                            r_iack_lvl <= M68K_ADDR[3:1];
                        end
                    end
                    ST_DECODE: begin
                        r_nwru <= w_nwru;
                        r_nwrl <= w_nwrl;
                        if (r_region == REG_TILE) begin
                            r_state <= ST_WAIT;
                            r_wcnt  <= 6'(TIMEOUT - 1);
                        end else if (w_ws == 6'd0) begin
                            r_state  <= ST_ACK;
                            r_ndtack <= 1'b0;
                            r_data   <= w_rdata;
                        end else begin
                            r_state <= ST_WAIT;
                            r_wcnt  <= w_ws - 6'd1;
                        end
                    end
                    ST_WAIT: begin
                        r_nwru <= w_nwru;
                        r_nwrl <= w_nwrl;
                        if (r_region == REG_TILE) begin
                            if (TILE_RDY) begin
                                r_state  <= ST_ACK;
                                r_ndtack <= 1'b0;
                                r_data   <= w_rdata;
                            end
`ifdef DTACK_TIMEOUT_EN
                            else if (r_wcnt == 6'd0) begin
                                r_state  <= ST_ACK;
                                r_ndtack <= 1'b0;
                                r_data   <= 16'hFFFF;
                                r_tmo    <= 1'b1;
                            end else begin
                                r_wcnt <= r_wcnt - 6'd1;
                            end
`endif
                        end else if (r_wcnt == 6'd0) begin
                            r_state  <= ST_ACK;
                            r_ndtack <= 1'b0;
                            r_data   <= w_rdata;
                        end else begin
                            r_wcnt <= r_wcnt - 6'd1;
                        end
                    end
                    ST_ACK: begin
                        r_nwru <= w_nwru;
                        r_nwrl <= w_nwrl;
                    end
                    ST_END:  r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign nDTACK       = r_ndtack;
    assign FX68K_DATAIN = r_data;
    assign nROMCS       = r_ncs[0];
    assign nRAMCS       = r_ncs[1];
    assign nTILECS      = r_ncs[2];
    assign nPALCS       = r_ncs[3];
    assign nIOCS        = r_ncs[4];
    assign nWRU         = r_nwru;
    assign nWRL         = r_nwrl;
    assign IACK         = r_iack;
    assign IACK_LVL     = r_iack_lvl;
`ifdef DTACK_TIMEOUT_EN
    assign TMO          = r_tmo;
`endif

endmodule

// File: doc/m68k_bus_ctrl.md
# m68k_bus_ctrl

Bus cycle controller sitting directly downstream of the 68000 core wrapper. It consumes the core's address strobe, data strobes, R/W and function codes. It decodes the address into device chip selects, inserts per-region wait states and generates nDTACK. It also returns the muxed read word on the core's data-in bus and answers interrupt-acknowledge cycles with an autovector number, since the core's VPAn is tied inactive.

## Interface
Parameters:
- WS_ROM, 2: wait cycles (clk) before DTACK for program ROM
- WS_RAM, 0: wait cycles for work RAM
- WS_PAL, 1: wait cycles for palette RAM
- WS_IO, 1: wait cycles for I/O registers
- TIMEOUT, 63: clk cycles to wait for TILE_RDY before forced DTACK (6-bit)

Ports (reset nRESET, asynchronous, active-low; clock clk):
- clk  in  1  2x CPU clock, same clock as the core
- nRESET  in  1  async active-low reset
- M68K_ADDR  in  23  word address [23:1]
- nAS, nUDS, nLDS  in  1 each  core strobes
- M68K_RW  in  1  1=read
- FC  in  3  function code
- nDTACK  out  1  to core
- FX68K_DATAIN  out  16  read word to core
- ROM_D, RAM_D, PAL_D, IO_D, TILE_D  in  16 each  device read data
- TILE_RDY  in  1  tilemap chip ready (slow device handshake)
- nROMCS, nRAMCS, nPALCS, nIOCS, nTILECS  out  1 each  chip selects
- nWRU, nWRL  out  1 each  byte write strobes
- IACK  out  1  one-clk pulse on interrupt acknowledge
- IACK_LVL  out  3  acknowledged level (ADDR[3:1])

## Operation
- Memory map: ROM 000000-05FFFF; RAM 060000-063FFF; TILE 100000-107FFF; PAL 140000-140FFF; IO 0A0000-0A001F; FC=111 is IACK. Any other address is UNMAPPED.
- FSM states: IDLE, DECODE, WAIT, ACK, END.
- IDLE -> DECODE when nAS sampled low.
- DECODE: latch region; load wait counter with the region's WS; assert its CS. Go to ACK if WS=0, else WAIT.
- TILE region: WAIT until TILE_RDY=1, then ACK.
- UNMAPPED: straight to ACK, read data 16'hFFFF.
- WAIT: count down; at 0 go to ACK.
- ACK: nDTACK=0; FX68K_DATAIN = selected device word (registered). Stay until nAS sampled high, then go to END.
- END: nDTACK=1, all CS high, return to IDLE. Back-to-back cycles therefore need nAS high for at least one sample.
- Writes: nWRU=nUDS, nWRL=nLDS, gated by RW=0 and region CS, from DECODE until END.
- IACK cycle: FX68K_DATAIN = {8'h00, 5'd3, ADDR[3:1]}, i.e. vector 24+level. IACK pulses in DECODE.
- nAS rising in any state before ACK aborts to END. No DTACK is issued.

## Timing
- Reset values: nDTACK=1, all CS=1, nWRU=nWRL=1, IACK=0, IACK_LVL=0, FX68K_DATAIN=0, state IDLE.
- nDTACK low at (2+WS) clk edges after the first edge sampling nAS low.
- Read data is valid on the same edge nDTACK falls and holds until END.
- nDTACK rises on the first edge after nAS is sampled high.
- Reset asserted mid-cycle forces reset values immediately and asynchronously.

## Configuration
- DTACK_TIMEOUT_EN defined: a TILE wait exceeding TIMEOUT clk cycles forces ACK with data 16'hFFFF and sets sticky output bit TMO (extra port, cleared by reset). This prevents a core lock-up.
- DTACK_TIMEOUT_EN undefined: TILE waits indefinitely; no TMO port.

## Structure
- Package m68k_bus_pkg holds: region enum (ROM, RAM, TILE, PAL, IO, IACK, UNMAPPED), region base/limit constants, FSM state enum.
- One sub-module, m68k_addr_decode: combinational address+FC to region.
- FSM, wait counter and data mux live in the top module.

## Test plan
- ROM read at 000100, WS_ROM=2, ROM_D=16'h4E71 -> nDTACK low 4 clk after nAS fall; FX68K_DATAIN=4E71; nROMCS low throughout.
- RAM byte write 060002, nUDS=0/nLDS=1 -> nWRU low, nWRL high; nDTACK low 2 clk after nAS.
- IACK level 5 (FC=111, ADDR[3:1]=101) -> IACK 1-clk pulse; IACK_LVL=5; FX68K_DATAIN=16'h001D.
- TILE read with TILE_RDY held low 10 clk -> nDTACK stays high; falls 1 clk after TILE_RDY rises.
- With DTACK_TIMEOUT_EN, TILE_RDY stuck low -> nDTACK low after 63 clk; data FFFF; TMO=1.
- nRESET pulsed during WAIT of a ROM cycle -> all outputs to reset values; next nAS cycle completes normally.
